// File: rtl/mips_trace_buffer_pkg.sv
// Shared types and record layout for the MIPS trace capture buffer.
// A trace record packs {direccion, palabra, leer_dato}, MSB to LSB.
package mips_dbg_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 64;

    localparam int TRACE_W = DEF_ADDR_W + 2 * DEF_DATA_W;
    localparam int LD_LSB  = 0;
    localparam int PAL_LSB = DEF_DATA_W;
    localparam int DIR_LSB = 2 * DEF_DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Observed core bus plus the indexed read-back port of the trace buffer.
// The observer (or bench) is the master; the buffer is the slave.
interface mips_trace_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic [ADDR_W-1:0] direccion;
    logic [DATA_W-1:0] palabra;
    logic [DATA_W-1:0] leer_dato;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid;
    logic              rd_err;
    logic [ADDR_W-1:0] rd_direccion;
    logic [DATA_W-1:0] rd_palabra;
    logic [DATA_W-1:0] rd_leer_dato;

    modport master (
        output direccion, palabra, leer_dato, rd_req, rd_idx,
        input  rd_valid, rd_err, rd_direccion, rd_palabra, rd_leer_dato
    );

    modport slave (
        input  direccion, palabra, leer_dato, rd_req, rd_idx,
        output rd_valid, rd_err, rd_direccion, rd_palabra, rd_leer_dato
    );
endinterface

// File: rtl/mips_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/mips_trace_buffer.sv
// Arm/trigger/post-count capture of the per-cycle MIPS bus tuple into a circular RAM,
// with an oldest-relative indexed read port once the window is frozen.
module mips_trace_buffer
    import mips_dbg_pkg::*;
#(
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_trace_buffer_if.slave bus,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic              force_trig,
    input  logic [IDX_W-1:0]  post_count,
    output logic [1:0]        state,
    output logic [IDX_W:0]    fill,
    output logic [IDX_W-1:0]  trig_pos
);
    localparam int REC_W = ADDR_W + 2 * DATA_W;
    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

    trace_state_t     state_reg, state_next;
    logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [IDX_W-1:0] post_cnt_reg, post_cnt_next;
    logic [IDX_W-1:0] post_len_reg, post_len_next;
    logic [IDX_W-1:0] trig_slot_reg, trig_slot_next;
    logic [IDX_W:0]   fill_reg, fill_next;
    logic             we, trig_hit, rd_ok;
    logic             rd_ok_reg, rd_valid_reg, rd_err_reg;
    logic [IDX_W-1:0] oldest, rd_addr;
    logic [REC_W-1:0] wr_rec, rd_rec;

    assign trig_hit = force_trig | (trig_en & (bus.direccion == trig_addr));
    // Once the ring has wrapped, the next slot to be written holds the oldest sample.
    assign oldest   = (fill_reg == FULL) ? wr_ptr_reg : '0;
    assign wr_rec   = {bus.direccion, bus.palabra, bus.leer_dato};

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        fill_next      = fill_reg;
        post_cnt_next  = post_cnt_reg;
        post_len_next  = post_len_reg;
        trig_slot_next = trig_slot_reg;
        we             = 1'b0;
        if (arm) begin
            state_next     = ARMED;
            wr_ptr_next    = '0;
            fill_next      = '0;
            post_cnt_next  = '0;
            trig_slot_next = '0;
        end else begin
            if (state_reg == ARMED || state_reg == POST) begin
                we          = 1'b1;
                wr_ptr_next = wr_ptr_reg + 1'b1;
                if (fill_reg != FULL) fill_next = fill_reg + 1'b1;
            end
            case (state_reg)
                ARMED: if (trig_hit) begin
                    trig_slot_next = wr_ptr_reg;
                    post_len_next  = post_count;
                    post_cnt_next  = '0;
                    state_next     = (post_count == '0) ? DONE : POST;
                end
                POST: begin
                    post_cnt_next = post_cnt_reg + 1'b1;
                    if (post_cnt_next == post_len_reg) state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
            post_cnt_reg  <= '0;
            post_len_reg  <= '0;
            trig_slot_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            fill_reg      <= fill_next;
            post_cnt_reg  <= post_cnt_next;
            post_len_reg  <= post_len_next;
            trig_slot_reg <= trig_slot_next;
        end
    end

    assign rd_ok   = bus.rd_req && (state_reg == DONE) && ({1'b0, bus.rd_idx} < fill_reg);
    assign rd_addr = oldest + bus.rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
            rd_ok_reg    <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_req;
            rd_err_reg   <= bus.rd_req & ~rd_ok;
            rd_ok_reg    <= rd_ok;
        end
    end

    trace_ram #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_rec),
        .rd_addr (rd_addr),
        .rd_data (rd_rec)
    );

    // RAM output is never reset, so gating with rd_ok_reg gives zero data on reset and errors.
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_err   = rd_err_reg;
    assign {bus.rd_direccion, bus.rd_palabra, bus.rd_leer_dato} = rd_ok_reg ? rd_rec : '0;

    assign state    = state_reg;
    assign fill     = fill_reg;
    assign trig_pos = trig_slot_reg - oldest;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed scenarios with random bus data, checked against a window-of-samples model.
module tb_mips_trace_buffer;
    localparam int AW = 32, DW = 32, DEPTH = 64, IW = 6;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] p;
        logic [31:0] l;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0, trig_en = 1'b0, force_trig = 1'b0;
    logic [AW-1:0] trig_addr = '0;
    logic [IW-1:0] post_count = '0;
    logic [1:0]    state;
    logic [IW:0]   fill;
    logic [IW-1:0] trig_pos;

    always #5 clk = ~clk;

    mips_trace_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) bus ();

    mips_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .arm(arm), .trig_en(trig_en),
        .trig_addr(trig_addr), .force_trig(force_trig), .post_count(post_count),
        .state(state), .fill(fill), .trig_pos(trig_pos)
    );

    // Reference model: all samples since arm, trimmed to the newest DEPTH.
    smp_t        win[$];
    int          m_state = 0, m_total = 0, m_trig = 0, m_plen = 0, m_pdone = 0;
    bit          p_valid = 0, p_err = 0;
    smp_t        p_data = '0;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] pc = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        smp_t s;
        bit   hit;
        s   = {bus.direccion, bus.palabra, bus.leer_dato};
        hit = force_trig || (trig_en && bus.direccion == trig_addr);
        p_valid = bus.rd_req;
        p_err   = 1'b1;
        p_data  = '0;
        if (bus.rd_req && m_state == 3 && int'(bus.rd_idx) < win.size()) begin
            p_err  = 1'b0;
            p_data = win[bus.rd_idx];
        end
        if (arm) begin
            m_state = 1; win.delete(); m_total = 0; m_pdone = 0;
        end else if (m_state == 1 || m_state == 2) begin
            win.push_back(s);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (m_state == 1 && hit) begin
                m_trig = m_total; m_plen = int'(post_count); m_pdone = 0;
                m_state = (post_count == 0) ? 3 : 2;
            end else if (m_state == 2) begin
                m_pdone++;
                if (m_pdone == m_plen) m_state = 3;
            end
            m_total++;
        end
    endtask

    task automatic check_outputs();
        int tp;
        chk("state", state, 128'(m_state));
        chk("fill", fill, 128'(win.size()));
        if (m_state >= 2) begin
            tp = ((m_trig - (m_total - win.size())) % DEPTH + DEPTH) % DEPTH;
            chk("trig_pos", trig_pos, 128'(tp));
        end
        chk("rd_valid", bus.rd_valid, 128'(p_valid));
        if (p_valid) begin
            chk("rd_err", bus.rd_err, 128'(p_err));
            chk("rd_data", {bus.rd_direccion, bus.rd_palabra, bus.rd_leer_dato}, 128'(p_data));
            $display("read idx=%0d err=%0b dir=%08h pal=%08h ld=%08h", bus.rd_idx, bus.rd_err,
                     bus.rd_direccion, bus.rd_palabra, bus.rd_leer_dato);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        arm = 1'b0; force_trig = 1'b0; bus.rd_req = 1'b0;
        bus.direccion = pc; pc += 32'd4;
        bus.palabra = $urandom; bus.leer_dato = $urandom;
    endtask

    task automatic read(input int idx);
        bus.rd_req = 1'b1; bus.rd_idx = IW'(idx);
        tick();
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && m_state != 3; i++) tick();
        chk("done_reached", state, 128'(3));
    endtask

    task automatic start(input logic [31:0] first_pc);
        pc = first_pc; arm = 1'b1;
        tick();
    endtask

    initial begin
        bus.direccion = '0; bus.palabra = '0; bus.leer_dato = '0;
        bus.rd_req = 1'b0; bus.rd_idx = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 128'(0));
        chk("rst_fill", fill, 128'(0));
        chk("rst_trig_pos", trig_pos, 128'(0));
        chk("rst_rd_valid", bus.rd_valid, 128'(0));
        chk("rst_rd_data", {bus.rd_direccion, bus.rd_palabra, bus.rd_leer_dato}, 128'(0));
        rst_n = 1'b1;
        tick();

        // 1: address-match trigger on PC 0x40, three post samples
        trig_en = 1'b1; trig_addr = 32'h40; post_count = 6'd3;
        start(32'h0);
        run_until_done(60);
        chk("t1_fill", fill, 128'(20));
        chk("t1_trig_pos", trig_pos, 128'(16));
        read(int'(trig_pos));
        chk("t1_trig_dir", bus.rd_direccion, 128'(32'h40));
        for (int i = 0; i <= 20; i++) read(i);
        trig_en = 1'b0;

        // 2: wrapped window, post_count changed after trigger must not matter
        post_count = 6'd10;
        start(32'h1000);
        repeat (100) tick();
        force_trig = 1'b1;
        tick();
        post_count = 6'd2;
        run_until_done(20);
        chk("t2_fill", fill, 128'(64));
        chk("t2_trig_pos", trig_pos, 128'(53));
        read(0); read(53); read(63);
        repeat (8) read($urandom_range(0, 63));

        // 3: post_count 0, force on 5th armed sample
        post_count = 6'd0;
        start(32'h2000);
        repeat (4) tick();
        force_trig = 1'b1;
        tick();
        chk("t3_state", state, 128'(3));
        chk("t3_fill", fill, 128'(5));
        chk("t3_trig_pos", trig_pos, 128'(4));

        // 4: out-of-range read, then read while not DONE
        read(5);
        chk("t4_oor_err", bus.rd_err, 128'(1));
        chk("t4_oor_dir", bus.rd_direccion, 128'(0));
        read(4);
        start(32'h3000);
        read(0);
        chk("t4_armed_err", bus.rd_err, 128'(1));

        // 5: asynchronous reset during POST with a read response outstanding
        post_count = 6'd20; force_trig = 1'b1;
        tick();
        repeat (3) tick();
        read(0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_state", state, 128'(0));
        chk("t5_fill", fill, 128'(0));
        chk("t5_trig_pos", trig_pos, 128'(0));
        chk("t5_rd_valid", bus.rd_valid, 128'(0));
        chk("t5_rd_err", bus.rd_err, 128'(0));
        m_state = 0; m_total = 0; win.delete(); p_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 6: arm during POST restarts the capture
        post_count = 6'd8;
        start(32'h4000);
        repeat (6) tick();
        force_trig = 1'b1;
        tick();
        repeat (3) tick();
        arm = 1'b1;
        tick();
        chk("t6_state", state, 128'(1));
        chk("t6_fill", fill, 128'(0));
        repeat (5) tick();
        force_trig = 1'b1;
        tick();
        run_until_done(20);
        for (int i = 0; i < 16; i++) read(i);

        // Randomised rounds
        for (int r = 0; r < 4; r++) begin
            post_count = IW'($urandom_range(0, 63));
            start($urandom & 32'hFFFF_FFFC);
            repeat ($urandom_range(0, 150)) tick();
            force_trig = 1'b1;
            tick();
            run_until_done(80);
            repeat (10) read($urandom_range(0, 63));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
